switch_alloc: RTL and testbench
===============================

SWITCH_ALLOC -- requirements
Module: switch_alloc

Interface
REQ-001 The module SHALL have parameter BUF_DEPTH, default 4, meaning the number of downstream buffer slots (credits) per output port, legal range 1..15.
REQ-002 The module SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, meaning the reset: asynchronous and active-low.
REQ-004 The module SHALL have port req_valid_i, input, 5, meaning one request bit per input port; bit order is 0=north, 1=south, 2=east, 3=west, 4=local, and this order applies to every 5-bit vector.
REQ-005 The module SHALL have ports req_port_addr1_i .. req_port_addr5_i, input, 3 each, meaning the requested output port for inputs 0..4 respectively; values 0..4 use the same encoding, and values 5..7 are invalid.
REQ-006 The module SHALL have ports credit_en_north, credit_en_south, credit_en_east, credit_en_west, credit_en_local, input, 1 each, meaning a one-cycle pulse that returns one freed downstream slot for that output.
REQ-007 The module SHALL have port grant_o, input-indexed, output, 5, meaning a registered one-cycle grant pulse to each input port.
REQ-008 The module SHALL have port out_valid_o, output-indexed, output, 5, meaning a registered pulse: that output's crossbar path is active this cycle.
REQ-009 The module SHALL have port xbar_sel_o, output, 15, meaning the registered source input index for each output; bits [3k+2:3k] serve output k.

Function
REQ-010 Each input SHALL request exactly one output, so arbitration SHALL be independent per output; no input can win two outputs in one cycle.
REQ-011 An input's request SHALL be eligible when req_valid_i is 1, its address is 0..4, its grant_o bit is 0 this cycle, and (under the macro) the target credit count is greater than 0.
REQ-012 A request with an invalid address (5..7) SHALL be ignored: no grant is issued, no credit is consumed and no pointer moves.
REQ-013 Each output SHALL keep a round-robin pointer 0..4; the search SHALL start at the pointer and proceed pointer, pointer+1, ... modulo 5, and the first eligible input SHALL win.
REQ-014 After a grant to input i, that output's pointer SHALL become (i+1) mod 5; with no grant, the pointer SHALL be unchanged.
REQ-015 Latency SHALL be one cycle: an eligible request sampled at edge N SHALL produce grant_o[i]=1, out_valid_o[k]=1 and xbar_sel_o[k]=i during cycle N+1, all high for exactly one cycle.
REQ-016 The requester SHALL hold req_valid_i and the address stable until it sees its grant; an input granted in cycle N+1 SHALL be masked from arbitration in N+1, so each input gets at most one grant per 2 cycles.
REQ-017 When out_valid_o[k]=0, xbar_sel_o[k] SHALL hold its last value.
REQ-018 Credit counters SHALL be 4-bit per output, reset to BUF_DEPTH; a grant decrements the count and credit_en increments it.
REQ-019 A grant and a credit_en on the same output in the same cycle SHALL leave the count unchanged.
REQ-020 A credit_en at count 0 SHALL make the credit usable only from the next cycle; no same-cycle bypass.
REQ-021 A credit_en at count BUF_DEPTH with no grant SHALL saturate (count stays at BUF_DEPTH) and SHALL set the sticky flag credit_ovf_q, which is cleared only by reset.
REQ-022 A grant SHALL never be issued at count 0, and the count SHALL never underflow.

Reset
REQ-023 On rst_n low, the module SHALL asynchronously force grant_o=0, out_valid_o=0, xbar_sel_o=0, all pointers=0, all credit counts=BUF_DEPTH and credit_ovf_q=0.
REQ-024 A reset asserted mid-operation SHALL abort any grant in flight, with no partial pulse after release.
REQ-025 The first grant SHALL come no earlier than the second rising edge after rst_n deasserts.

Configuration
REQ-026 Macro SWALLOC_CREDIT_CHECK_EN defined: the credit counters and credit gating (REQ-011, REQ-018 to REQ-022) SHALL be present.
REQ-027 Macro SWALLOC_CREDIT_CHECK_EN undefined: the module SHALL have no counters, SHALL ignore the credit_en_* inputs, SHALL grant regardless of credit, SHALL keep credit_ovf_q at 0, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL check single request: after reset, req_valid_i=00001 with addr1=2 -> in the next cycle grant_o=00001, out_valid_o=00100, xbar_sel_o[8:6]=0, and the east credit count is 3.
REQ-029 The bench SHALL check round-robin: all 5 inputs request output 4 continuously with credits returned every cycle -> grants go to inputs 0,1,2,3,4,0 in that order, and no input is granted in two consecutive cycles.
REQ-030 The bench SHALL check credit exhaustion: with BUF_DEPTH=4, input 1 requests north and no credit_en arrives -> exactly 4 grants, then none; one credit_en_north pulse -> exactly one more grant, issued 2 cycles after the pulse.
REQ-031 The bench SHALL check simultaneous events: a north grant and credit_en_north in the same cycle at count 2 -> the count stays 2, and credit_en at count 4 -> credit_ovf_q=1.
REQ-032 The bench SHALL check invalid address: addr3=6 with req_valid_i[2]=1 for 10 cycles -> grant_o[2] stays 0 and all counts and pointers are unchanged.
REQ-033 The bench SHALL check reset mid-operation: rst_n pulled low in the same cycle a grant is registered -> all outputs are 0 immediately and the pointers and counts are back at their reset values.

Source files
------------

// File: rtl/switch_alloc.sv
// ---------------------------------------------------------------------------
// switch_alloc -- five-port router switch allocator.
//
// Each input asks for exactly one output, so every output runs its own
// round-robin arbiter over the five inputs. Grants, crossbar-active pulses
// and crossbar select values are registered: a request sampled on one rising
// edge produces its one-cycle grant in the following cycle. An input that is
// showing a grant is masked for that cycle, so one input wins at most every
// other cycle.
//
// Optional feature (macro SWALLOC_CREDIT_CHECK_EN):
//   defined   -> 4-bit per-output credit counters gate arbitration; a grant
//                consumes a credit, credit_en_* returns one, and a return at
//                full count saturates and sets the sticky credit_ovf_q.
//   undefined -> no counters; credit_en_* ignored; credit_ovf_q tied to 0.
//
// Parameters
//   BUF_DEPTH         downstream slots per output, 1..15 (default 4)
// Ports (port vector bit order: 0=north 1=south 2=east 3=west 4=local)
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   req_valid_i[4:0]  request per input port
//   req_port_addr1_i..req_port_addr5_i [2:0]
//                     requested output for inputs 0..4 (5..7 invalid)
//   credit_en_north/south/east/west/local
//                     one-cycle credit return per output
//   grant_o[4:0]      registered grant pulse, input-indexed
//   out_valid_o[4:0]  registered crossbar-active pulse, output-indexed
//   xbar_sel_o[14:0]  source input of output k in bits [3k+2:3k]
//   credit_ovf_q      sticky credit overflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module switch_alloc #(
  parameter int BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  req_valid_i,
  input  logic [2:0]  req_port_addr1_i,
  input  logic [2:0]  req_port_addr2_i,
  input  logic [2:0]  req_port_addr3_i,
  input  logic [2:0]  req_port_addr4_i,
  input  logic [2:0]  req_port_addr5_i,
  input  logic        credit_en_north,
  input  logic        credit_en_south,
  input  logic        credit_en_east,
  input  logic        credit_en_west,
  input  logic        credit_en_local,
  output logic [4:0]  grant_o,
  output logic [4:0]  out_valid_o,
  output logic [14:0] xbar_sel_o,
  output logic        credit_ovf_q
);

  logic [2:0] w_addr [5];
  logic [4:0] w_cred_en;
  logic [4:0] w_elig;
  logic [4:0] w_has_cred;
  logic [4:0] w_gnt;
  logic [4:0] w_ovld;
  logic [2:0] w_win [5];
  logic [2:0] r_ptr [5];
  logic       r_arb_en;

  assign w_addr[0] = req_port_addr1_i;
  assign w_addr[1] = req_port_addr2_i;
  assign w_addr[2] = req_port_addr3_i;
  assign w_addr[3] = req_port_addr4_i;
  assign w_addr[4] = req_port_addr5_i;
  assign w_cred_en = {credit_en_local, credit_en_west, credit_en_east,
                      credit_en_south, credit_en_north};

  // An input currently showing its grant is masked so it cannot be granted
  // again off the same (still held) request.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < 5; i++) begin
      w_elig[i] = req_valid_i[i] && (w_addr[i] <= 3'd4) && !grant_o[i];
    end
  end

  // Per-output round-robin search starting at the pointer, modulo 5.
  always_comb begin
    logic [3:0] v_sum;
    logic [2:0] v_idx;
    v_sum  = '0;
    v_idx  = '0;
    w_gnt  = '0;
    w_ovld = '0;
    for (int k = 0; k < 5; k++) begin
      w_win[k] = '0;
      if (r_arb_en && w_has_cred[k]) begin
        for (int j = 0; j < 5; j++) begin
          v_sum = {1'b0, r_ptr[k]} + 4'(j);
          if (v_sum > 4'd4) v_sum = v_sum - 4'd5;
          v_idx = v_sum[2:0];
          if (!w_ovld[k] && w_elig[v_idx] && (w_addr[v_idx] == 3'(k))) begin
            w_ovld[k]    = 1'b1;
            w_win[k]     = v_idx;
            w_gnt[v_idx] = 1'b1;
          end
        end
      end
    end
  end

  // r_arb_en holds off arbitration for the first edge after reset release,
  // so nothing can be granted off a request sampled on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arb_en    <= 1'b0;
      grant_o     <= '0;
      out_valid_o <= '0;
      xbar_sel_o  <= '0;
      for (int k = 0; k < 5; k++) r_ptr[k] <= '0;
    end else begin
      r_arb_en    <= 1'b1;
      grant_o     <= w_gnt;
      out_valid_o <= w_ovld;
      for (int k = 0; k < 5; k++) begin
        if (w_ovld[k]) begin
          xbar_sel_o[3*k +: 3] <= w_win[k];
          r_ptr[k]             <= (w_win[k] == 3'd4) ? 3'd0 : w_win[k] + 3'd1;
        end
      end
    end
  end

`ifdef SWALLOC_CREDIT_CHECK_EN
  localparam logic [3:0] LP_DEPTH = 4'(BUF_DEPTH);

  logic [3:0] r_cnt [5];
  logic       r_ovf;

  // Gating uses the registered count only: a credit returned this cycle
  // becomes usable from the next cycle.
  always_comb begin
    w_has_cred = '0;
    for (int k = 0; k < 5; k++) w_has_cred[k] = (r_cnt[k] != 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      for (int k = 0; k < 5; k++) r_cnt[k] <= LP_DEPTH;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (w_cred_en[k] && !w_ovld[k]) begin
          if (r_cnt[k] == LP_DEPTH) r_ovf <= 1'b1;
          else                      r_cnt[k] <= r_cnt[k] + 4'd1;
        end else if (!w_cred_en[k] && w_ovld[k]) begin
          r_cnt[k] <= r_cnt[k] - 4'd1;
        end
      end
    end
  end

  assign credit_ovf_q = r_ovf;
`else
  localparam logic [3:0] LP_UNUSED_DEPTH = 4'(BUF_DEPTH);
  logic w_unused_cred;

  assign w_unused_cred = ^w_cred_en;
  assign w_has_cred    = '1;
  assign credit_ovf_q  = 1'b0;
`endif

endmodule

// File: tb/tb_switch_alloc.sv
module tb_switch_alloc;

  localparam int BUF_DEPTH = 4;
`ifdef SWALLOC_CREDIT_CHECK_EN
  localparam bit CRED = 1'b1;
`else
  localparam bit CRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  req_valid_i = '0;
  logic [2:0]  req_port_addr1_i = '0, req_port_addr2_i = '0, req_port_addr3_i = '0;
  logic [2:0]  req_port_addr4_i = '0, req_port_addr5_i = '0;
  logic        credit_en_north = 1'b0, credit_en_south = 1'b0, credit_en_east = 1'b0;
  logic        credit_en_west = 1'b0, credit_en_local = 1'b0;
  logic [4:0]  grant_o, out_valid_o;
  logic [14:0] xbar_sel_o;
  logic        credit_ovf_q;

  switch_alloc #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i),
    .req_port_addr1_i(req_port_addr1_i), .req_port_addr2_i(req_port_addr2_i),
    .req_port_addr3_i(req_port_addr3_i), .req_port_addr4_i(req_port_addr4_i),
    .req_port_addr5_i(req_port_addr5_i),
    .credit_en_north(credit_en_north), .credit_en_south(credit_en_south),
    .credit_en_east(credit_en_east), .credit_en_west(credit_en_west),
    .credit_en_local(credit_en_local),
    .grant_o(grant_o), .out_valid_o(out_valid_o), .xbar_sel_o(xbar_sel_o),
    .credit_ovf_q(credit_ovf_q)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the outputs should show after each edge.
  logic [4:0]  m_gnt, m_ovld;
  logic [14:0] m_sel;
  int          m_ptr [5];
  int          m_cnt [5];
  logic        m_ovf, m_arb_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt = '0; m_ovld = '0; m_sel = '0; m_ovf = 1'b0; m_arb_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      m_ptr[k] = 0;
      m_cnt[k] = BUF_DEPTH;
    end
  endtask

  // One rising edge of the allocator, from the rules: per output, first
  // eligible requester in pointer order wins; credits count grants/returns.
  task automatic model_edge(input logic [4:0] v, input logic [14:0] a, input logic [4:0] ce);
    logic [4:0] ng, no, elig;
    int ai [5];
    int win, ii;
    ng = '0; no = '0; elig = '0;
    for (int i = 0; i < 5; i++) begin
      ai[i]   = int'(a[3*i +: 3]);
      elig[i] = v[i] && (ai[i] < 5) && !m_gnt[i];
    end
    for (int k = 0; k < 5; k++) begin
      if (m_arb_en && (!CRED || m_cnt[k] > 0)) begin
        win = -1;
        for (int j = 0; j < 5; j++) begin
          ii = (m_ptr[k] + j) % 5;
          if (win < 0 && elig[ii] && ai[ii] == k) win = ii;
        end
        if (win >= 0) begin
          ng[win] = 1'b1;
          no[k]   = 1'b1;
          m_sel[3*k +: 3] = 3'(win);
          m_ptr[k] = (win + 1) % 5;
        end
      end
    end
    if (CRED) begin
      for (int k = 0; k < 5; k++) begin
        if (ce[k] && !no[k]) begin
          if (m_cnt[k] == BUF_DEPTH) m_ovf = 1'b1;
          else m_cnt[k] = m_cnt[k] + 1;
        end else if (!ce[k] && no[k]) begin
          m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
    m_gnt = ng; m_ovld = no; m_arb_en = 1'b1;
  endtask

  task automatic check_outputs();
    chk("grant_o", 32'(grant_o), 32'(m_gnt));
    chk("out_valid_o", 32'(out_valid_o), 32'(m_ovld));
    chk("xbar_sel_o", 32'(xbar_sel_o), 32'(m_sel));
    chk("credit_ovf_q", 32'(credit_ovf_q), 32'(m_ovf));
  endtask

  task automatic step(input logic [4:0] v, input logic [14:0] a, input logic [4:0] ce);
    @(negedge clk);
    req_valid_i = v;
    req_port_addr1_i = a[2:0];   req_port_addr2_i = a[5:3];
    req_port_addr3_i = a[8:6];   req_port_addr4_i = a[11:9];
    req_port_addr5_i = a[14:12];
    {credit_en_local, credit_en_west, credit_en_east, credit_en_south, credit_en_north} = ce;
    @(posedge clk);
    model_edge(v, a, ce);
    #1;
    check_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_grant"}, 32'(grant_o), 32'd0);
    chk({tag, "_ovld"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_sel"}, 32'(xbar_sel_o), 32'd0);
    chk({tag, "_ovf"}, 32'(credit_ovf_q), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_ptr"}, 32'(dut.r_ptr[k]), 32'd0);
`ifdef SWALLOC_CREDIT_CHECK_EN
      chk({tag, "_cnt"}, 32'(dut.r_cnt[k]), 32'(BUF_DEPTH));
`endif
    end
  endtask

  initial begin
    logic [4:0]  rv, prev_g;
    logic [14:0] ra;
    logic [4:0]  ce;
    int gcnt, first_at, w;
    int rr_exp [6];
    int snap_ptr [5];
    int snap_cnt [5];
    rr_exp = '{0, 1, 2, 3, 4, 0};

    // Reset state, held across a clock edge.
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(posedge clk); #1;
    check_reset_state("reset_hold");
    @(posedge clk); #2 rst_n = 1'b1;

    // Single request north->east; first edge after release grants nothing.
    ra = '0; ra[2:0] = 3'd2;
    step(5'b00001, ra, 5'b0);
    chk("first_edge_no_grant", 32'(grant_o), 32'd0);
    step(5'b00001, ra, 5'b0);
    chk("single_grant", 32'(grant_o), 32'b00001);
    chk("single_ovld", 32'(out_valid_o), 32'b00100);
    chk("single_sel_east", 32'(xbar_sel_o[8:6]), 32'd0);
`ifdef SWALLOC_CREDIT_CHECK_EN
    chk("single_east_cnt", 32'(dut.r_cnt[2]), 32'd3);
`endif
    step(5'b0, '0, 5'b0);

    // Round robin: all five inputs hold a request for local.
    ra = {5{3'd4}};
    prev_g = '0;
    for (int c = 0; c < 6; c++) begin
      step(5'b11111, ra, 5'b10000);
      w = -1;
      for (int i = 0; i < 5; i++) if (grant_o[i]) w = i;
      chk("rr_order", 32'(w), 32'(rr_exp[c]));
      chk("rr_no_back_to_back", 32'(grant_o & prev_g), 32'd0);
      prev_g = grant_o;
    end
    step(5'b0, '0, 5'b0);

    // Credit exhaustion: input 1 asks for north with no returns.
    ra = '0;
    gcnt = 0;
    for (int c = 0; c < 12; c++) begin
      step(5'b00010, ra, 5'b0);
      gcnt += int'(grant_o[1]);
    end
    chk("exhaust_grants", 32'(gcnt), CRED ? 32'd4 : 32'd6);
    gcnt = 0; first_at = -1;
    for (int c = 0; c < 6; c++) begin
      step(5'b00010, ra, (c == 0) ? 5'b00001 : 5'b0);
      if (grant_o[1]) begin
        gcnt++;
        if (first_at < 0) first_at = c;
      end
    end
`ifdef SWALLOC_CREDIT_CHECK_EN
    chk("refill_one_grant", 32'(gcnt), 32'd1);
    chk("refill_grant_delay", 32'(first_at), 32'd1);
`endif
    step(5'b0, '0, 5'b0);

    // Grant and credit return together at count 2, then overflow at full.
    step(5'b0, '0, 5'b00001);
    step(5'b0, '0, 5'b00001);
`ifdef SWALLOC_CREDIT_CHECK_EN
    chk("sim_cnt_before", 32'(dut.r_cnt[0]), 32'd2);
`endif
    step(5'b00010, ra, 5'b00001);
    chk("sim_grant", 32'(grant_o[1]), 32'd1);
`ifdef SWALLOC_CREDIT_CHECK_EN
    chk("sim_cnt_after", 32'(dut.r_cnt[0]), 32'd2);
`endif
    step(5'b0, '0, 5'b00001);
    step(5'b0, '0, 5'b00001);
    step(5'b0, '0, 5'b00001);
    chk("ovf_flag", 32'(credit_ovf_q), 32'(CRED));

    // Invalid address on input 2 for ten cycles.
    for (int k = 0; k < 5; k++) begin
      snap_ptr[k] = m_ptr[k];
      snap_cnt[k] = m_cnt[k];
    end
    ra = '0; ra[8:6] = 3'd6;
    for (int c = 0; c < 10; c++) begin
      step(5'b00100, ra, 5'b0);
      chk("inv_grant2", 32'(grant_o[2]), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      chk("inv_ptr", 32'(dut.r_ptr[k]), 32'(snap_ptr[k]));
`ifdef SWALLOC_CREDIT_CHECK_EN
      chk("inv_cnt", 32'(dut.r_cnt[k]), 32'(snap_cnt[k]));
`endif
    end
    step(5'b0, '0, 5'b0);

    // Random traffic: requesters hold until granted; invalid ones may give up.
    rv = '0; ra = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (rv[i] && m_gnt[i]) rv[i] = 1'b0;
        else if (rv[i] && ra[3*i +: 3] > 3'd4 && $urandom_range(3) == 0) rv[i] = 1'b0;
        else if (!rv[i] && $urandom_range(2) == 0) begin
          rv[i] = 1'b1;
          ra[3*i +: 3] = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 5))
                                                 : 3'($urandom_range(4));
        end
      end
      ce = 5'($urandom) & 5'($urandom);
      step(rv, ra, ce);
    end
    for (int c = 0; c < 5; c++) step(5'b0, '0, 5'b11111);

    // Reset in the cycle a west grant is showing.
    ra = '0; ra[11:9] = 3'd3;
    step(5'b01000, ra, 5'b0);
    chk("pre_reset_grant", 32'(grant_o[3]), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_state("midop_reset");
    model_reset();
    #1 rst_n = 1'b1;
    step(5'b01000, ra, 5'b0);
    chk("post_reset_no_pulse", 32'(grant_o), 32'd0);
    step(5'b01000, ra, 5'b0);
    chk("post_reset_grant", 32'(grant_o[3]), 32'd1);
    step(5'b0, '0, 5'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
